ysyx_22040125_pc_gen: RTL
=========================

Name: ysyx_22040125_pc_gen

Overview:
- Program-counter generation stage; sits directly downstream of the branch checker and consumes its 3-bit `pc_sel` decision.
- Holds the fetch PC and issues fetch requests to IF over a valid/ready handshake.
- Computes the redirect target for branch, jal, jalr, trap and mret, and flushes wrong-path instructions.
- Holds a redirect that arrives while a fetch request is outstanding, so the presented address stays stable until accepted.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, fetch address after reset
XLEN, 64, datapath width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active-low
ex_valid  in  1  pc_sel/ex_pc/imm/rs1_data are valid this cycle
pc_sel  in  3  next-PC select from branch checker (already resolved)
ex_pc  in  64  PC of the instruction producing pc_sel
imm  in  64  sign-extended immediate
rs1_data  in  64  rs1 operand (jalr)
mtvec  in  64  trap vector CSR
mepc  in  64  exception PC CSR
stall  in  1  downstream cannot take a new instruction
if_ready  in  1  IF accepts request
if_valid  out  1  fetch request valid
if_pc  out  64  fetch address
if_kill  out  1  request handshaking this cycle is wrong-path; IF discards its response
flush  out  1  kill younger in-flight instructions (1-cycle pulse)
misalign_exc  out  1  redirect target misaligned (1-cycle pulse)

Behaviour:
- Reset, checked on clk edge while rst_n=0:
  - pc_q=RESET_PC; state=IDLE; pend_q=0; issued_q=0.
  - Outputs: if_valid=0, if_kill=0, flush=0, misalign_exc=0, if_pc=RESET_PC.
- A reset asserted mid-request abandons the request; no handshake completion is required.
- Targets, pc_sel encoding:
  - 000: sequential; not a redirect.
  - 001 jal: ex_pc+imm.
  - 010 branch taken: ex_pc+imm.
  - 011 jalr: (rs1_data+imm)&~64'h1.
  - 100 trap: {mtvec[63:2],2'b00}.
  - 101 mret: mepc.
  - 110/111: treated as 000.
- All adds are modulo 2^64; wrap-around is silent.
- redirect = ex_valid & (pc_sel is 001..101).
- States: IDLE, REQ, PEND.
- IDLE: if_valid=0. Goes to REQ on the first cycle after reset release.
- REQ:
  - if_valid = ~stall | issued_q; if_pc=pc_q.
  - issued_q is set when if_valid & ~if_ready, and cleared on handshake. Once asserted, if_valid never drops before handshake, regardless of stall.
  - Handshake without redirect: pc_q<=pc_q+4.
  - Redirect with handshake, or redirect with if_valid=0: pc_q<=target, stay REQ, if_kill=1 if handshaking.
  - Redirect with if_valid=1 & ~if_ready: pend_q<=target, go PEND. pc_q and if_pc are held.
- PEND:
  - if_valid=1, if_pc=pc_q.
  - On if_ready: if_kill=1, pc_q<=pend_q, go REQ.
  - A new redirect in PEND overwrites pend_q; the newest wins. If it coincides with if_ready, the new target goes directly to pc_q.
- flush: registered; pulses the cycle after any redirect is captured, in any state.
- Simultaneous stall and redirect: the redirect is taken; stall only gates new request issue.
- Latency: redirect in cycle N → if_pc=target presented in cycle N+1 (REQ path), or the cycle after the held request's handshake (PEND path).

Optional Feature:
- Macro: YSYX_22040125_RVC_EN.
- Defined: targets need only 2-byte alignment; bit0 is cleared for all targets; misalign_exc is tied 0.
- Undefined: a target with bit1=1 (pc_sel 001/010/011) is not taken. Instead:
  - misalign_exc pulses for 1 cycle (registered, aligned with flush);
  - the target is replaced by {mtvec[63:2],2'b00} via the same redirect path.

Test Plan:
- Reset then if_ready=1 constantly → if_pc sequence 8000_0000, 8000_0004, 8000_0008; if_valid=0 in the first post-reset cycle.
- if_ready=0 for 3 cycles → if_valid stays 1 and if_pc stays 8000_0004; stall toggling has no effect.
- Branch: ex_valid=1, pc_sel=010, ex_pc=8000_0010, imm=-16, if_ready=1 → next if_pc=8000_0000; flush pulses once; if_kill=1 on the redirect cycle.
- jalr with if_ready=0: rs1=8000_0101, imm=3 → PEND; when if_ready=1, if_kill=1, then if_pc=8000_0104.
- Trap (100, mtvec=8000_0203) then mret (101, mepc=8000_0040) on consecutive cycles in PEND → final if_pc=8000_0040.
- Without RVC_EN, branch target 8000_0002 → misalign_exc=1 and if_pc=mtvec aligned. With RVC_EN → if_pc=8000_0002, misalign_exc=0.

Source files
------------

// File: rtl/ysyx_22040125_pc_gen.sv
// Fetch-PC generation: holds the fetch PC, issues IF requests and applies
// branch/jal/jalr/trap/mret redirects. Optional macro YSYX_22040125_RVC_EN relaxes target alignment.
module ysyx_22040125_pc_gen #(
    parameter int unsigned    XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [2:0]      pc_sel,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            stall,
    input  logic            if_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic            if_kill,
    output logic            flush,
    output logic            misalign_exc
);

    typedef enum logic [1:0] {StIdle, StReq, StPend} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            issued_q, issued_d;
    logic            flush_q, misalign_q;

    logic            redirect;
    logic            misalign;
    logic            req_valid;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] raw_target;
    logic [XLEN-1:0] target;

    assign trap_target = {mtvec[XLEN-1:2], 2'b00};
    assign redirect    = ex_valid && (pc_sel >= 3'b001) && (pc_sel <= 3'b101);

    always_comb begin
        raw_target = ex_pc + imm;
        case (pc_sel)
            3'b011:  raw_target = (rs1_data + imm) & {{(XLEN-1){1'b1}}, 1'b0};
            3'b100:  raw_target = trap_target;
            3'b101:  raw_target = mepc;
            default: raw_target = ex_pc + imm;
        endcase
    end

`ifdef YSYX_22040125_RVC_EN
    assign misalign = 1'b0;
    assign target   = {raw_target[XLEN-1:1], 1'b0};
`else
    // Only pc-relative and jalr targets can be misaligned; they fall back to the trap vector.
    assign misalign = redirect && (pc_sel <= 3'b011) && raw_target[1];
    assign target   = misalign ? trap_target : raw_target;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        issued_d  = issued_q;
        req_valid = 1'b0;
        if_kill   = 1'b0;
        case (state_q)
            StIdle: begin
                state_d = StReq;
                if (redirect) begin
                    pc_d = target;
                end
            end
            StReq: begin
                // Once presented, a request stays up until accepted, whatever stall does.
                req_valid = !stall || issued_q;
                if (redirect && req_valid && !if_ready) begin
                    pend_d   = target;
                    issued_d = 1'b1;
                    state_d  = StPend;
                end else if (redirect) begin
                    pc_d     = target;
                    if_kill  = req_valid;
                    issued_d = 1'b0;
                end else if (req_valid && if_ready) begin
                    pc_d     = pc_q + XLEN'(4);
                    issued_d = 1'b0;
                end else if (req_valid) begin
                    issued_d = 1'b1;
                end
            end
            StPend: begin
                req_valid = 1'b1;
                if (if_ready) begin
                    if_kill  = 1'b1;
                    pc_d     = redirect ? target : pend_q;
                    issued_d = 1'b0;
                    state_d  = StReq;
                end else if (redirect) begin
                    pend_d = target;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            issued_q   <= 1'b0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            issued_q   <= issued_d;
            flush_q    <= redirect;
            misalign_q <= misalign;
        end
    end

    assign if_valid     = req_valid;
    assign if_pc        = pc_q;
    assign flush        = flush_q;
    assign misalign_exc = misalign_q;

endmodule
